rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ writeback sources
//  (req 0 = ALU, req 1 = load/store unit). Round-robin arbitration, one registered
//  write stage, halt-aware. Drives write_enable_i/waddr_i/data_i of register_file.
//  Exports a pending-write bitmap so issue logic can stall on RAW hazards.
// PARAMETERS
//  XLEN     32 (rriscv_pkg)   data width; also the register count
//  NUM_REQ  2                 number of writeback requesters (>=2)
//  ADDR_W   $clog2(XLEN)      register address width
// PORTS
//  clk_i        in   1               clock, all state on rising edge
//  rst_i        in   1               synchronous reset, active-high
//  halt_i       in   1               core halt; freezes the arbiter
//  flush_i      in   1               block new grants this cycle
//  req_valid_i  in   NUM_REQ         requester has a write
//  req_addr_i   in   NUM_REQ*ADDR_W  destination register, per requester
//  req_data_i   in   NUM_REQ*XLEN    write data, per requester
//  req_ready_o  out  NUM_REQ         write accepted this cycle (one-hot or 0)
//  rf_we_o      out  1               to register_file write_enable_i
//  rf_waddr_o   out  ADDR_W          to register_file waddr_i
//  rf_wdata_o   out  XLEN            to register_file data_i
//  grant_idx_o  out  $clog2(NUM_REQ) index of requester held in write stage
//  pending_o    out  XLEN            bit r = 1: write to xr held in stage, not committed
// BEHAVIOUR
//  Reset (rst_i=1 at edge): stage valid=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0,
//   grant_idx_o=0, pending_o=0, RR pointer=0 (req 0 highest priority).
//   Reset wins over halt_i/flush_i; an uncommitted stage entry is discarded.
//  Handshake: transfer = req_valid_i[k] & req_ready_o[k]. req_ready_o is
//   combinational: 0 for all k if halt_i|flush_i. Otherwise 1 only for the winner.
//   Requester holds addr/data stable until accepted; valid may not drop unaccepted.
//  Arbitration: scan from RR pointer upward, wrapping modulo NUM_REQ. Grant the first
//   valid requester. After a grant, pointer = winner+1 mod NUM_REQ. With no grant,
//   the pointer is unchanged. Two continuously valid requesters alternate.
//  Write stage: on a grant the stage loads at the next edge: addr, data, grant_idx.
//   It is valid only if addr != 0; a grant to x0 is accepted and dropped
//   (rf_we_o=0, no pending bit). Latency: accept at cycle t -> rf_we_o=1 in t+1.
//   The register file commits at the end of t+1.
//  Drain: if !halt_i, a valid stage commits that cycle. It is then reloaded by a new
//   grant or cleared. Sustained throughput is 1 write/cycle.
//  Halt: stage and RR pointer frozen; rf_we_o/addr/data stay asserted (the register
//   file ignores them). The first cycle with halt_i=0 commits the held write.
//  Flush: no grant, pointer unchanged; the stage still drains normally.
//  pending_o: one-hot(rf_waddr_o) when the stage is valid, else 0. Bit 0 is never set.
//  Same-address writes from two requesters in one cycle: serialized in RR order.
//   The later grant overwrites the earlier one in the register file.
// TESTING
//  1 reset: rst_i=1 for 2 cycles with req_valid_i=2'b11 -> ready=0, rf_we_o=0,
//    pending_o=0.
//  2 single write: req0 x5=0xDEAD_BEEF at t -> ready0=1 @t; @t+1 rf_we_o=1,
//    waddr=5, pending_o=32'h20; readback of x5 = 0xDEADBEEF.
//  3 contention: both valid for 4 cycles (x1,x2) -> grants 0,1,0,1;
//    grant_idx_o follows one cycle later.
//  4 x0: req1 addr=0, data=0xFFFF_FFFF -> ready1=1, rf_we_o stays 0,
//    pending_o=0, x0 reads 0.
//  5 halt: accept x7=0x1234, then halt_i=1 for 3 cycles -> ready=0, rf_we_o held 1,
//    pending_o[7]=1; x7 commits in the first cycle after halt drops.
//  6 flush+reset mid-op: flush_i with both valid -> no ready, stage drains.
//    rst_i while stage valid -> entry dropped, x-reg unchanged.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback
// sources, with one registered write stage, halt freeze and a pending-write bitmap.
module rf_write_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = $clog2(XLEN),
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      halt_i,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      rf_we_o,
    output logic [ADDR_W-1:0]         rf_waddr_o,
    output logic [XLEN-1:0]           rf_wdata_o,
    output logic [IDX_W-1:0]          grant_idx_o,
    output logic [XLEN-1:0]           pending_o
);

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              stage_valid_q, stage_valid_d;
    logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
    logic [XLEN-1:0]   stage_data_q, stage_data_d;
    logic [IDX_W-1:0]  stage_idx_q, stage_idx_d;

    logic              grant_found;
    logic              grant_en;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W:0]    cand_sum;
    logic [ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]   sel_data;

    // Scan upward from the RR pointer, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_data = req_data_i[i*XLEN +: XLEN];
            end
        end
    end

    assign grant_en = grant_found & ~(rst_i | halt_i | flush_i);

    always_comb begin
        req_ready_o = '0;
        if (grant_en) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // A valid stage drains every non-halted cycle; a grant to x0 loads but stays invalid.
    always_comb begin
        ptr_d         = ptr_q;
        stage_valid_d = stage_valid_q;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        stage_idx_d   = stage_idx_q;
        if (!halt_i) begin
            if (grant_en) begin
                stage_valid_d = (sel_addr != '0);
                stage_addr_d  = sel_addr;
                stage_data_d  = sel_data;
                stage_idx_d   = grant_idx;
                ptr_d         = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                stage_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            stage_idx_q   <= '0;
        end else begin
            ptr_q         <= ptr_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
            stage_idx_q   <= stage_idx_d;
        end
    end

    // Write enable is masked during reset so an uncommitted entry never reaches the file.
    assign rf_we_o     = stage_valid_q & ~rst_i;
    assign rf_waddr_o  = stage_addr_q;
    assign rf_wdata_o  = stage_data_q;
    assign grant_idx_o = stage_idx_q;

    always_comb begin
        pending_o = '0;
        if (rf_we_o) begin
            pending_o[stage_addr_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a behavioural RR/write-stage model checked every
// cycle, a register-file image built from the DUT's writes, and literal expectations.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_i, halt_i, flush_i;
    logic [1:0]  req_valid_i, req_ready_o;
    logic [9:0]  req_addr_i;
    logic [63:0] req_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [0:0]  grant_idx_o;
    logic [31:0] pending_o;

    int checks   = 0;
    int failures = 0;

    rf_write_arbiter #(.XLEN(32), .NUM_REQ(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .halt_i(halt_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .grant_idx_o(grant_idx_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    // Register file image: commits only while not halted.
    logic [31:0] rf [32] = '{default: '0};
    always @(posedge clk) if (rf_we_o && !halt_i) rf[rf_waddr_o] <= rf_wdata_o;

    // Behavioural model state.
    bit          started = 1'b0;
    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    int          m_idx   = 0;

    function automatic int rr_pick(input logic [1:0] v, input int ptr);
        for (int i = 0; i < 2; i++)
            if (((v >> ((ptr + i) % 2)) & 2'b01) != 2'b00) return (ptr + i) % 2;
        return -1;
    endfunction

    function automatic logic [4:0] addr_of(input int k);
        return 5'(req_addr_i >> (k * 5));
    endfunction

    function automatic logic [31:0] data_of(input int k);
        return 32'(req_data_i >> (k * 32));
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            started <= 1'b1;
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_idx   <= 0;
        end else if (!halt_i) begin
            if (!flush_i && rr_pick(req_valid_i, m_ptr) >= 0) begin
                m_idx   <= rr_pick(req_valid_i, m_ptr);
                m_addr  <= addr_of(rr_pick(req_valid_i, m_ptr));
                m_data  <= data_of(rr_pick(req_valid_i, m_ptr));
                m_valid <= addr_of(rr_pick(req_valid_i, m_ptr)) != 5'd0;
                m_ptr   <= (rr_pick(req_valid_i, m_ptr) + 1) % 2;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        int p = rr_pick(req_valid_i, m_ptr);
        logic [1:0] er = (rst_i || halt_i || flush_i || p < 0) ? 2'b00 : 2'(1 << p);
        bit ew = m_valid && !rst_i;
        check("m_ready", 32'(req_ready_o), 32'(er));
        check("m_we", 32'(rf_we_o), 32'(ew));
        check("m_pending", pending_o, ew ? (32'd1 << m_addr) : 32'd0);
        if (ew) begin
            check("m_waddr", 32'(rf_waddr_o), 32'(m_addr));
            check("m_wdata", rf_wdata_o, m_data);
            check("m_grant_idx", 32'(grant_idx_o), 32'(m_idx));
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (started) model_compare();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
        req_addr_i[k*5 +: 5]   = a;
        req_data_i[k*32 +: 32] = d;
    endtask

    logic [1:0]  c_v  [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
    logic [31:0] c_d0 [5] = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h102};
    logic [31:0] c_d1 [5] = '{32'h200, 32'h200, 32'h201, 32'h201, 32'h201};
    logic [1:0]  c_er [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [31:0] c_gi [5] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};

    initial begin
        rst_i = 1'b1; halt_i = 1'b0; flush_i = 1'b0; req_valid_i = 2'b11;
        req_addr_i = '0; req_data_i = '0;
        set_req(0, 5'd1, 32'h1111); set_req(1, 5'd2, 32'h2222);
        adv();
        // reset, second cycle
        sample();
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_we", 32'(rf_we_o), 32'd0);
        check("rst_pending", pending_o, 32'd0);
        adv();
        rst_i = 1'b0; req_valid_i = 2'b00;
        sample(); adv();

        // single write x5
        req_valid_i = 2'b01; set_req(0, 5'd5, 32'hDEAD_BEEF);
        sample(); check("single_ready", 32'(req_ready_o), 32'h1); adv();
        req_valid_i = 2'b00;
        sample();
        check("single_we", 32'(rf_we_o), 32'd1);
        check("single_waddr", 32'(rf_waddr_o), 32'd5);
        check("single_pending", pending_o, 32'h20);
        adv();
        sample(); check("single_rf_x5", rf[5], 32'hDEAD_BEEF); adv();

        // write to x0 by req1
        req_valid_i = 2'b10; set_req(1, 5'd0, 32'hFFFF_FFFF);
        sample(); check("x0_ready", 32'(req_ready_o), 32'h2); adv();
        req_valid_i = 2'b00;
        sample();
        check("x0_we", 32'(rf_we_o), 32'd0);
        check("x0_pending", pending_o, 32'd0);
        adv();
        sample(); check("x0_rf", rf[0], 32'd0); adv();

        // contention x1 vs x2
        for (int i = 0; i < 5; i++) begin
            req_valid_i = c_v[i]; set_req(0, 5'd1, c_d0[i]); set_req(1, 5'd2, c_d1[i]);
            sample();
            check("rr_ready", 32'(req_ready_o), 32'(c_er[i]));
            if (i > 0) check("rr_grant_idx", 32'(grant_idx_o), c_gi[i-1]);
            adv();
        end
        req_valid_i = 2'b00;
        sample();
        check("rr_grant_idx_last", 32'(grant_idx_o), c_gi[4]);
        check("rr_waddr_last", 32'(rf_waddr_o), 32'd1);
        adv();
        sample();
        check("rr_rf_x1", rf[1], 32'h102);
        check("rr_rf_x2", rf[2], 32'h201);
        adv();

        // halt holds the accepted x7 write
        req_valid_i = 2'b01; set_req(0, 5'd7, 32'h1234);
        sample(); check("halt_accept", 32'(req_ready_o), 32'h1); adv();
        halt_i = 1'b1; req_valid_i = 2'b10; set_req(1, 5'd9, 32'h99);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("halt_ready", 32'(req_ready_o), 32'd0);
            check("halt_we", 32'(rf_we_o), 32'd1);
            check("halt_pending", pending_o, 32'h80);
            adv();
        end
        halt_i = 1'b0;
        sample();
        check("halt_rf_x7_held", rf[7], 32'd0);
        check("halt_release_waddr", 32'(rf_waddr_o), 32'd7);
        check("halt_release_ready", 32'(req_ready_o), 32'h2);
        adv();
        req_valid_i = 2'b00;
        sample();
        check("halt_rf_x7", rf[7], 32'h1234);
        check("halt_next_waddr", 32'(rf_waddr_o), 32'd9);
        adv();
        sample(); check("halt_rf_x9", rf[9], 32'h99); adv();

        // flush drains, reset drops the staged entry
        req_valid_i = 2'b01; set_req(0, 5'd3, 32'h33);
        sample(); check("fl_accept", 32'(req_ready_o), 32'h1); adv();
        flush_i = 1'b1; req_valid_i = 2'b11;
        set_req(0, 5'd10, 32'hAA); set_req(1, 5'd4, 32'h44);
        sample();
        check("fl_ready", 32'(req_ready_o), 32'd0);
        check("fl_drain_we", 32'(rf_we_o), 32'd1);
        check("fl_drain_waddr", 32'(rf_waddr_o), 32'd3);
        adv();
        flush_i = 1'b0;
        sample();
        check("fl_after_ready", 32'(req_ready_o), 32'h2);
        check("fl_after_we", 32'(rf_we_o), 32'd0);
        adv();
        rst_i = 1'b1; req_valid_i = 2'b01;
        sample();
        check("mid_rst_ready", 32'(req_ready_o), 32'd0);
        check("mid_rst_we", 32'(rf_we_o), 32'd0);
        adv();
        rst_i = 1'b0;
        sample();
        check("mid_rst_rf_x4", rf[4], 32'd0);
        check("mid_rst_rf_x3", rf[3], 32'h33);
        check("post_rst_ready", 32'(req_ready_o), 32'h1);
        adv();
        req_valid_i = 2'b00;
        sample(); check("post_rst_waddr", 32'(rf_waddr_o), 32'd10); adv();
        sample(); check("post_rst_rf_x10", rf[10], 32'hAA); adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
